// File: rtl/agc_gain_sequencer.sv
// AGC gain sequencer: applies saturating +/-1 gain steps on request, enforces an
// analog settling window after each step, and declares lock on oscillation,
// persistent saturation or step budget exhaustion.
module agc_gain_sequencer #(
    parameter int GAIN_W     = 5,
    parameter int GAIN_INIT  = 16,
    parameter int SETTLE_CYC = 4,
    parameter int REV_LIMIT  = 3,
    parameter int SAT_LIMIT  = 2,
    parameter int MAX_STEPS  = 24
) (
    input  logic              clk,
    input  logic              RESETn,
    input  logic              enable,
    input  logic              adjust,
    input  logic              up_dn,
    output logic [GAIN_W-1:0] gain_code,
    output logic              gain_update,
    output logic              settling,
    output logic              sat_hi,
    output logic              sat_lo,
    output logic              done,
    output logic [7:0]        step_count
);

    localparam int TMR_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int REV_W = $clog2(REV_LIMIT + 1);
    localparam int SAT_W = $clog2(SAT_LIMIT + 1);

    localparam logic [GAIN_W-1:0] GAIN_MAX   = {GAIN_W{1'b1}};
    localparam logic [GAIN_W-1:0] GAIN_ZERO  = '0;
    localparam logic [GAIN_W-1:0] GAIN_ONE   = GAIN_W'(1);
    localparam logic [GAIN_W-1:0] GAIN_START = GAIN_W'(GAIN_INIT);
    localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0]  TMR_ZERO   = '0;
    localparam logic [TMR_W-1:0]  TMR_ONE    = TMR_W'(1);
    localparam logic [REV_W-1:0]  REV_LIM    = REV_W'(REV_LIMIT);
    localparam logic [REV_W-1:0]  REV_ONE    = REV_W'(1);
    localparam logic [SAT_W-1:0]  SAT_LIM    = SAT_W'(SAT_LIMIT);
    localparam logic [SAT_W-1:0]  SAT_ONE    = SAT_W'(1);
    localparam logic [7:0]        STEP_LIM   = 8'(MAX_STEPS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SETTLE,
        LOCKED
    } state_t;

    state_t            state,        state_nxt;
    logic [GAIN_W-1:0] gain_nxt;
    logic [7:0]        step_nxt;
    logic [REV_W-1:0]  rev_cnt,      rev_nxt;
    logic [SAT_W-1:0]  sat_cnt,      sat_nxt;
    logic [TMR_W-1:0]  timer,        timer_nxt;
    logic              last_dir,     last_dir_nxt;
    logic              last_dir_vld, last_dir_vld_nxt;
    logic              update_nxt;
    logic              step_blocked;

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state        <= IDLE;
            gain_code    <= GAIN_START;
            step_count   <= '0;
            rev_cnt      <= '0;
            sat_cnt      <= '0;
            timer        <= '0;
            last_dir     <= 1'b0;
            last_dir_vld <= 1'b0;
            gain_update  <= 1'b0;
            sat_hi       <= (GAIN_START == GAIN_MAX);
            sat_lo       <= (GAIN_START == GAIN_ZERO);
        end else begin
            state        <= state_nxt;
            gain_code    <= gain_nxt;
            step_count   <= step_nxt;
            rev_cnt      <= rev_nxt;
            sat_cnt      <= sat_nxt;
            timer        <= timer_nxt;
            last_dir     <= last_dir_nxt;
            last_dir_vld <= last_dir_vld_nxt;
            gain_update  <= update_nxt;
            sat_hi       <= (gain_nxt == GAIN_MAX);
            sat_lo       <= (gain_nxt == GAIN_ZERO);
        end
    end

    // A request is blocked when the step would wrap the gain code.
    assign step_blocked = up_dn ? (gain_code == GAIN_MAX) : (gain_code == GAIN_ZERO);

    always_comb begin
        state_nxt        = state;
        gain_nxt         = gain_code;
        step_nxt         = step_count;
        rev_nxt          = rev_cnt;
        sat_nxt          = sat_cnt;
        timer_nxt        = timer;
        last_dir_nxt     = last_dir;
        last_dir_vld_nxt = last_dir_vld;
        update_nxt       = 1'b0;

        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt        = WAIT;
                    gain_nxt         = GAIN_START;
                    step_nxt         = '0;
                    rev_nxt          = '0;
                    sat_nxt          = '0;
                    last_dir_vld_nxt = 1'b0;
                end
                WAIT: begin
                    if (adjust) begin
                        if (step_blocked) begin
                            if (sat_cnt != SAT_LIM) begin
                                sat_nxt = sat_cnt + SAT_ONE;
                            end
                            if (sat_nxt == SAT_LIM) begin
                                state_nxt = LOCKED;
                            end
                        end else begin
                            gain_nxt = up_dn ? (gain_code + GAIN_ONE) : (gain_code - GAIN_ONE);
                            if (step_count != 8'hFF) begin
                                step_nxt = step_count + 8'd1;
                            end
                            sat_nxt = '0;
                            // Only a change of direction against a known previous step counts.
                            if (last_dir_vld && (up_dn != last_dir) && (rev_cnt != REV_LIM)) begin
                                rev_nxt = rev_cnt + REV_ONE;
                            end
                            last_dir_nxt     = up_dn;
                            last_dir_vld_nxt = 1'b1;
                            timer_nxt        = TMR_LOAD;
                            update_nxt       = 1'b1;
                            state_nxt        = SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (timer == TMR_ZERO) begin
                        if ((rev_cnt >= REV_LIM) || (step_count >= STEP_LIM)) begin
                            state_nxt = LOCKED;
                        end else begin
                            state_nxt = WAIT;
                        end
                    end else begin
                        timer_nxt = timer - TMR_ONE;
                    end
                end
                LOCKED: begin
                    state_nxt = LOCKED;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign settling = (state == SETTLE);
    assign done     = (state == LOCKED);

endmodule

// File: tb/tb_agc_gain_sequencer.sv
// Self-checking bench for agc_gain_sequencer: directed vector table, hand-written
// corner sequences and randomized stimulus against a behavioural model.
module tb_agc_gain_sequencer;

    logic       clk = 1'b0;
    logic       RESETn;
    logic       enable;
    logic       adjust;
    logic       up_dn;
    logic [4:0] gain_code;
    logic       gain_update;
    logic       settling;
    logic       sat_hi;
    logic       sat_lo;
    logic       done;
    logic [7:0] step_count;

    int total = 0;
    int bad   = 0;

    // Behavioural model: applied step directions kept as a history list.
    bit m_run;
    bit m_lock;
    bit m_upd;
    int m_code;
    int m_settle;
    int m_sat;
    bit m_dirs[$];

    typedef struct {
        logic       en;
        logic       adj;
        logic       ud;
        logic [4:0] code;
        logic       upd;
        logic       set;
        logic       dn;
        logic [7:0] steps;
    } vec_t;

    vec_t tbl[9];

    always #5 clk = ~clk;

    agc_gain_sequencer dut (
        .clk        (clk),
        .RESETn     (RESETn),
        .enable     (enable),
        .adjust     (adjust),
        .up_dn      (up_dn),
        .gain_code  (gain_code),
        .gain_update(gain_update),
        .settling   (settling),
        .sat_hi     (sat_hi),
        .sat_lo     (sat_lo),
        .done       (done),
        .step_count (step_count)
    );

    function automatic int reversals();
        int r = 0;
        for (int i = 1; i < m_dirs.size(); i++) begin
            if (m_dirs[i] != m_dirs[i-1]) r++;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_run    = 1'b0;
        m_lock   = 1'b0;
        m_upd    = 1'b0;
        m_code   = 16;
        m_settle = 0;
        m_sat    = 0;
        m_dirs.delete();
    endtask

    task automatic model_edge(input logic en, input logic adj, input logic ud);
        m_upd = 1'b0;
        if (!en) begin
            m_run    = 1'b0;
            m_lock   = 1'b0;
            m_settle = 0;
        end else if (!m_run) begin
            m_run    = 1'b1;
            m_lock   = 1'b0;
            m_code   = 16;
            m_settle = 0;
            m_sat    = 0;
            m_dirs.delete();
        end else if (m_lock) begin
            m_lock = 1'b1;
        end else if (m_settle > 0) begin
            m_settle--;
            if (m_settle == 0 && (reversals() >= 3 || m_dirs.size() >= 24)) m_lock = 1'b1;
        end else if (adj) begin
            if ((ud && m_code == 31) || (!ud && m_code == 0)) begin
                m_sat++;
                if (m_sat >= 2) m_lock = 1'b1;
            end else begin
                m_code   = ud ? m_code + 1 : m_code - 1;
                m_dirs.push_back(ud);
                m_sat    = 0;
                m_settle = 4;
                m_upd    = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name);
        logic [31:0] act;
        logic [31:0] exp;
        int          steps;
        logic        m_settling;
        steps      = (m_dirs.size() > 255) ? 255 : m_dirs.size();
        m_settling = m_run && !m_lock && (m_settle > 0);
        act = {14'd0, gain_code, gain_update, settling, sat_hi, sat_lo, done, step_count};
        exp = {14'd0, 5'(m_code), m_upd, m_settling, (m_code == 31), (m_code == 0), m_lock, 8'(steps)};
        check(name, act, exp);
    endtask

    task automatic applyStimulus(input logic en, input logic adj, input logic ud);
        enable = en;
        adjust = adj;
        up_dn  = ud;
        @(posedge clk);
        model_edge(en, adj, ud);
        #1;
        checkOutput("model");
    endtask

    task automatic async_reset();
        #2;
        RESETn = 1'b0;
        model_reset();
        #1;
        checkOutput("async_reset");
        @(negedge clk);
        RESETn = 1'b1;
    endtask

    initial begin
        int n;
        int done_edge;
        int last_upd;
        int n_upd;
        int spacing_bad;
        int k;
        logic dir;
        logic [4:0] codes[4];
        logic en_r;
        logic adj_r;

        RESETn = 1'b0;
        enable = 1'b0;
        adjust = 1'b0;
        up_dn  = 1'b0;
        model_reset();
        #12;
        check("reset_state", {14'd0, gain_code, gain_update, settling, sat_hi, sat_lo, done, step_count},
              {14'd0, 5'd16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
        @(negedge clk);
        RESETn = 1'b1;

        // Directed vectors from reset: restart, one step through its settle window, abort, restart.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 5'd16, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 5'd17, 1'b1, 1'b1, 1'b0, 8'd1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 5'd17, 1'b0, 1'b1, 1'b0, 8'd1};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 5'd17, 1'b0, 1'b1, 1'b0, 8'd1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 5'd17, 1'b0, 1'b1, 1'b0, 8'd1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 5'd17, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 5'd16, 1'b1, 1'b1, 1'b0, 8'd2};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 5'd16, 1'b0, 1'b0, 1'b0, 8'd2};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 5'd16, 1'b0, 1'b0, 1'b0, 8'd0};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i].en, tbl[i].adj, tbl[i].ud);
            check($sformatf("vec%0d", i),
                  {14'd0, gain_code, gain_update, settling, done, step_count, sat_hi, sat_lo},
                  {14'd0, tbl[i].code, tbl[i].upd, tbl[i].set, tbl[i].dn, tbl[i].steps, 2'b00});
        end

        // Saturation lock: hold up requests from a fresh start.
        applyStimulus(1'b0, 1'b0, 1'b0);
        n = 0; done_edge = -1; last_upd = -100; n_upd = 0; spacing_bad = 0;
        while (n < 200 && done_edge < 0) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            if (gain_update) begin
                if (n_upd > 0 && n - last_upd != 5) spacing_bad++;
                last_upd = n;
                n_upd++;
            end
            if (done) done_edge = n;
            n++;
        end
        check("sat_done_edge", done_edge, 77);
        check("sat_updates", n_upd, 15);
        check("sat_spacing", spacing_bad, 0);
        check("sat_code", {sat_hi, gain_code, step_count}, {1'b1, 5'd31, 8'd15});
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        check("sat_hold", {done, gain_code}, {1'b1, 5'd31});

        // Oscillation lock: flip direction after every applied step.
        applyStimulus(1'b0, 1'b0, 1'b0);
        n = 0; k = 0; dir = 1'b1; done_edge = -1; last_upd = -100;
        while (n < 100 && done_edge < 0) begin
            applyStimulus(1'b1, 1'b1, dir);
            if (gain_update) begin
                if (k < 4) codes[k] = gain_code;
                k++;
                dir = ~dir;
                last_upd = n;
            end
            if (done) done_edge = n;
            n++;
        end
        check("osc_steps", k, 4);
        check("osc_codes", {12'd0, codes[0], codes[1], codes[2], codes[3]}, {12'd0, 5'd17, 5'd16, 5'd17, 5'd16});
        check("osc_done_delay", done_edge - last_upd, 4);
        check("osc_hold", {done, gain_code, step_count}, {1'b1, 5'd16, 8'd4});

        // Step budget: 16 steps down to zero, then up until the budget runs out.
        applyStimulus(1'b0, 1'b0, 1'b0);
        n = 0; dir = 1'b0; done_edge = -1;
        while (n < 400 && done_edge < 0) begin
            applyStimulus(1'b1, 1'b1, dir);
            if (step_count == 8'd16) dir = 1'b1;
            if (done) done_edge = n;
            n++;
        end
        check("budget_done_edge", done_edge, 120);
        check("budget_state", {done, gain_code, step_count}, {1'b1, 5'd8, 8'd24});

        // Abort in the second settle cycle, then re-enable.
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        check("abort_idle", {settling, done, gain_update, gain_code}, {1'b0, 1'b0, 1'b0, 5'd17});
        n_upd = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (gain_update) n_upd++;
        end
        check("abort_no_update", {n_upd[7:0], gain_code}, {8'd0, 5'd17});
        applyStimulus(1'b1, 1'b0, 1'b0);
        check("abort_restart", {gain_code, step_count}, {5'd16, 8'd0});

        // Asynchronous reset between edges while settling.
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        #3;
        RESETn = 1'b0;
        model_reset();
        #1;
        check("async_mid_settle", {gain_code, gain_update, settling, done, step_count},
              {5'd16, 1'b0, 1'b0, 1'b0, 8'd0});
        @(negedge clk);
        RESETn = 1'b1;

        // Randomized run against the model, with occasional aborts and resets.
        dir = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) async_reset();
            en_r  = ($urandom_range(0, 99) > 1);
            adj_r = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 99) < 25) dir = ~dir;
            applyStimulus(en_r, adj_r, dir);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
